// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between the instruction-fetch bus
// (read-only) and the data bus (read/write). One requester is granted per
// cycle with round-robin fairness. The read return is steered to the owner of
// the access one cycle after its grant. Cycles in which both buses request at
// once are counted in a saturating profiling counter.

module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_Clk,
  input  logic              i_Rstn,
  // instruction bus (read-only)
  input  logic              i_I_Req,
  input  logic [ADDR_W-1:0] i_I_Addr,
  output logic              o_I_Gnt,
  output logic              o_I_Valid,
  output logic [DATA_W-1:0] o_I_RData,
  // data bus (read/write)
  input  logic              i_D_Req,
  input  logic              i_D_We,
  input  logic [ADDR_W-1:0] i_D_Addr,
  input  logic [DATA_W-1:0] i_D_WData,
  output logic              o_D_Gnt,
  output logic              o_D_Valid,
  output logic [DATA_W-1:0] o_D_RData,
  // memory port
  output logic              o_Mem_En,
  output logic              o_Mem_We,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [DATA_W-1:0] o_Mem_WData,
  input  logic [DATA_W-1:0] i_Mem_RData,
  // core stall and profiling
  output logic              o_Stall,
  input  logic              i_CntClr,
  output logic [CNT_W-1:0]  o_ConflictCnt
);

  // Requester identifiers used for last-grant and read-owner tracking.
  localparam logic ID_I = 1'b0;
  localparam logic ID_D = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             last_gnt_r;
  logic             rd_pend_r;
  logic             rd_owner_r;
  logic [CNT_W-1:0] conflict_cnt_r;

  logic             i_gnt_s;
  logic             d_gnt_s;
  logic             any_gnt_s;
  logic             gnt_id_s;
  logic             gnt_is_read_s;
  logic             conflict_s;

  assign conflict_s = i_I_Req & i_D_Req;

  // Round-robin arbitration: a lone requester always wins; on a conflict the
  // requester that did not win the previous grant goes first.
  always_comb begin
    i_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    case ({i_I_Req, i_D_Req})
      2'b10: i_gnt_s = 1'b1;
      2'b01: d_gnt_s = 1'b1;
      2'b11: begin
        if (last_gnt_r == ID_D) begin
          i_gnt_s = 1'b1;
        end else begin
          d_gnt_s = 1'b1;
        end
      end
      default: begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
      end
    endcase
  end

  assign any_gnt_s     = i_gnt_s | d_gnt_s;
  assign gnt_id_s      = d_gnt_s ? ID_D : ID_I;
  assign gnt_is_read_s = i_gnt_s | (d_gnt_s & ~i_D_We);

  // Memory port drive: the granted requester's access, all zero when idle.
  always_comb begin
    o_Mem_En    = 1'b0;
    o_Mem_We    = 1'b0;
    o_Mem_Addr  = {ADDR_W{1'b0}};
    o_Mem_WData = {DATA_W{1'b0}};
    if (d_gnt_s) begin
      o_Mem_En    = 1'b1;
      o_Mem_We    = i_D_We;
      o_Mem_Addr  = i_D_Addr;
      o_Mem_WData = i_D_WData;
    end else if (i_gnt_s) begin
      o_Mem_En    = 1'b1;
      o_Mem_Addr  = i_I_Addr;
    end else begin
      o_Mem_En    = 1'b0;
    end
  end

  assign o_I_Gnt = i_gnt_s;
  assign o_D_Gnt = d_gnt_s;
  assign o_Stall = (i_I_Req & ~i_gnt_s) | (i_D_Req & ~d_gnt_s);

  // Grant history and outstanding-read tracking; reset favours IBUS first.
  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      last_gnt_r <= ID_D;
      rd_pend_r  <= 1'b0;
      rd_owner_r <= ID_I;
    end else if (any_gnt_s) begin
      last_gnt_r <= gnt_id_s;
      rd_pend_r  <= gnt_is_read_s;
      rd_owner_r <= gnt_id_s;
    end else begin
      rd_pend_r  <= 1'b0;
    end
  end

  // Saturating contention counter; the clear takes priority over a count.
  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      conflict_cnt_r <= {CNT_W{1'b0}};
    end else if (i_CntClr) begin
      conflict_cnt_r <= {CNT_W{1'b0}};
    end else if (conflict_s && (conflict_cnt_r != CNT_MAX)) begin
      conflict_cnt_r <= conflict_cnt_r + CNT_ONE;
    end
  end

  // Read data is shared; only the valid flag tells the buses apart.
  assign o_I_Valid     = rd_pend_r & (rd_owner_r == ID_I);
  assign o_D_Valid     = rd_pend_r & (rd_owner_r == ID_D);
  assign o_I_RData     = i_Mem_RData;
  assign o_D_RData     = i_Mem_RData;
  assign o_ConflictCnt = conflict_cnt_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed stimulus with hand-computed
// expectations; read returns are checked by a scoreboard monitor.

module tb_mem_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_valid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              cnt_clr;
  logic [CNT_W-1:0]  conflict_cnt;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_Clk(clk), .i_Rstn(rst_n),
    .i_I_Req(i_req), .i_I_Addr(i_addr), .o_I_Gnt(i_gnt),
    .o_I_Valid(i_valid), .o_I_RData(i_rdata),
    .i_D_Req(d_req), .i_D_We(d_we), .i_D_Addr(d_addr), .i_D_WData(d_wdata),
    .o_D_Gnt(d_gnt), .o_D_Valid(d_valid), .o_D_RData(d_rdata),
    .o_Mem_En(mem_en), .o_Mem_We(mem_we), .o_Mem_Addr(mem_addr),
    .o_Mem_WData(mem_wdata), .i_Mem_RData(mem_rdata),
    .o_Stall(stall), .i_CntClr(cnt_clr), .o_ConflictCnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- memory model: synchronous single port, 1-cycle read latency ----
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return {16'hC0DE, 6'b000000, a};
  endfunction

  initial begin
    for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = init_val(ADDR_W'(k));
    mem_rdata = 32'h0000_0000;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // ---- bookkeeping ----
  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---- scoreboard of expected read returns ----
  typedef struct {
    int                cyc;
    logic              own;   // 0 = IBUS, 1 = DBUS
    logic [DATA_W-1:0] dat;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      mon_e = q.pop_front();
      chk("late_valid", {30'd0, i_valid, d_valid}, 32'd1);
    end
    if (i_valid || d_valid) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        mon_e = q.pop_front();
        chk("valid_onehot", {31'd0, i_valid & d_valid}, 32'd0);
        chk("valid_owner", {31'd0, d_valid}, {31'd0, mon_e.own});
        chk("rdata", mon_e.own ? d_rdata : i_rdata, mon_e.dat);
      end else begin
        chk("spurious_valid", {30'd0, i_valid, d_valid}, 32'd0);
      end
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      mon_e = q.pop_front();
      chk("missing_valid", {31'd0, i_valid | d_valid}, 32'd1);
    end
  end

  // One cycle of stimulus: drive, check combinational outputs mid-cycle,
  // queue the expected read return for the following cycle.
  task automatic step(input logic ir, input logic [ADDR_W-1:0] ia,
                      input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                      input logic [DATA_W-1:0] dwd, input logic clr,
                      input logic e_ig, input logic e_dg, input logic e_stall,
                      input logic [DATA_W-1:0] e_dat);
    exp_t e;
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    cnt_clr = clr;
    @(negedge clk);
    chk("i_gnt", {31'd0, i_gnt}, {31'd0, e_ig});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, e_dg});
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    chk("mem_en", {31'd0, mem_en}, {31'd0, e_ig | e_dg});
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_dg & dw});
    if (e_ig) chk("mem_addr", {22'd0, mem_addr}, {22'd0, ia});
    if (e_dg) chk("mem_addr", {22'd0, mem_addr}, {22'd0, da});
    if (e_dg && dw) chk("mem_wdata", mem_wdata, dwd);
    if (e_ig || (e_dg && !dw)) begin
      e.cyc = cyc + 1; e.own = e_dg; e.dat = e_dat;
      q.push_back(e);
    end
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- directed stimulus ----
  logic [ADDR_W-1:0] ia;
  logic [ADDR_W-1:0] da;

  initial begin
    rst_n = 1'b0; i_req = 1'b0; i_addr = 10'h000; d_req = 1'b0; d_we = 1'b0;
    d_addr = 10'h000; d_wdata = 32'h0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_i_valid", {31'd0, i_valid}, 32'd0);
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_cnt", {28'd0, conflict_cnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;

    // first conflict after reset: IBUS first, then DBUS
    step(1'b1, 10'h010, 1'b1, 1'b0, 10'h020, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, init_val(10'h010));
    step(1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, init_val(10'h020));

    // IBUS-only back-to-back reads
    step(1'b1, 10'h004, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, init_val(10'h004));
    step(1'b1, 10'h008, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, init_val(10'h008));

    // DBUS write then read back
    step(1'b0, 10'h000, 1'b1, 1'b1, 10'h040, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 10'h000, 1'b1, 1'b0, 10'h040, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);

    // one conflict so far; clear it
    chk("cnt_one", {28'd0, conflict_cnt}, 32'd1);
    step(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("cnt_cleared", {28'd0, conflict_cnt}, 32'd0);

    // 10 cycles of contention: strict I,D alternation
    ia = 10'h100; da = 10'h200;
    for (int j = 0; j < 10; j++) begin
      if (j % 2 == 0) begin
        step(1'b1, ia, 1'b1, 1'b0, da, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, init_val(ia));
        ia = ia + 10'd1;
      end else begin
        step(1'b1, ia, 1'b1, 1'b0, da, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, init_val(da));
        da = da + 10'd1;
      end
    end
    chk("cnt_ten", {28'd0, conflict_cnt}, 32'd10);

    // clear together with a conflict: clear wins
    step(1'b1, ia, 1'b1, 1'b0, da, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, init_val(ia));
    ia = ia + 10'd1;
    chk("cnt_clr_wins", {28'd0, conflict_cnt}, 32'd0);

    // 20 cycles of contention, DBUS first after last IBUS grant; saturate at 15
    for (int j = 0; j < 20; j++) begin
      if (j % 2 == 0) begin
        step(1'b1, ia, 1'b1, 1'b0, da, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, init_val(da));
        da = da + 10'd1;
      end else begin
        step(1'b1, ia, 1'b1, 1'b0, da, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, init_val(ia));
        ia = ia + 10'd1;
      end
    end
    chk("cnt_sat", {28'd0, conflict_cnt}, 32'd15);
    idle();
    chk("cnt_sat_hold", {28'd0, conflict_cnt}, 32'd15);

    // IBUS read granted, reset pulsed before its return: no valid afterwards
    i_req = 1'b1; i_addr = 10'h3F0;
    @(negedge clk);
    chk("pre_rst_gnt", {31'd0, i_gnt}, 32'd1);
    #2 rst_n = 1'b0;
    i_req = 1'b0; i_addr = 10'h000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_i_valid", {31'd0, i_valid}, 32'd0);
    chk("post_rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("post_rst_cnt", {28'd0, conflict_cnt}, 32'd0);
    @(posedge clk); #1;

    // arbitration restarts with IBUS priority
    step(1'b1, 10'h011, 1'b1, 1'b0, 10'h022, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, init_val(10'h011));
    step(1'b0, 10'h000, 1'b1, 1'b0, 10'h022, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, init_val(10'h022));
    idle();
    idle();
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
